rob_superscalar_buffer: RTL
===========================

// Module: rob_superscalar_buffer
// PURPOSE
// Multi-issue reorder buffer: up to DISPATCH_WIDTH entries enter per cycle in program order.
// Up to CDB_PORTS completions are written per cycle. Up to COMMIT_WIDTH ready entries retire in order.
// Sits between dispatch/rename, the CDB arbiter and the commit/regfile stage.
// Mispredicting branches squash all younger entries in one cycle.
// PARAMETERS
// NUM_ENTRIES    16  entry count; power of 2, >= max(DISPATCH_WIDTH, COMMIT_WIDTH)
// DISPATCH_WIDTH 2   enqueue lanes; also sets the number of operand read ports (2 per lane)
// COMMIT_WIDTH   2   retire lanes
// CDB_PORTS      2   completion write ports
// DATA_W         32  result width
// PAYLOAD_W      64  opaque per-entry info (pc, rd, flags); stored and returned unchanged
// PORTS  (IDX_W = $clog2(NUM_ENTRIES))
// clk             in   1                 clock
// rst             in   1                 synchronous, active-high reset
// enq_valid       in   DISPATCH_WIDTH    lane request; must be a contiguous prefix from lane 0
// enq_payload     in   DISPATCH_WIDTH*PAYLOAD_W  per-lane payload
// enq_ready       out  1                 all lanes may enqueue this cycle
// enq_idx         out  DISPATCH_WIDTH*IDX_W      allocated index per lane (comb)
// cdb_valid       in   CDB_PORTS         completion valid
// cdb_idx         in   CDB_PORTS*IDX_W   completing entry
// cdb_data        in   CDB_PORTS*DATA_W  result value
// cdb_mispredict  in   CDB_PORTS         entry is a mispredicted branch; squash younger
// rs_idx          in   2*DISPATCH_WIDTH*IDX_W    operand lookup index
// rs_ready        out  2*DISPATCH_WIDTH  entry holds its result
// rs_value        out  2*DISPATCH_WIDTH*DATA_W   entry result
// commit_valid    out  COMMIT_WIDTH      retire lane valid (registered)
// commit_idx      out  COMMIT_WIDTH*IDX_W       retired index
// commit_payload  out  COMMIT_WIDTH*PAYLOAD_W   retired payload
// commit_data     out  COMMIT_WIDTH*DATA_W      retired result
// count           out  IDX_W+1           occupied entries (registered)
// BEHAVIOUR
// - Pointers: head/tail are IDX_W+1 bits with a wrap bit. empty = head==tail.
//   count = tail-head, mod 2^(IDX_W+1).
// - enq_ready = (NUM_ENTRIES-count >= DISPATCH_WIDTH) && !(any cdb_valid&cdb_mispredict).
// - Accepting lane i writes entry tail+i: valid=1, ready=0. tail advances by popcount(enq_valid & enq_ready).
//   A non-prefix enq_valid pattern is illegal; flag it with an assertion.
// - CDB write: sets ready and the result on a valid entry. Writes to invalid entries are ignored.
// - Same-index CDB writes in one cycle are illegal; flag it with an assertion.
// - Mispredict: the port whose entry is oldest (age = idx-head mod NUM_ENTRIES) wins.
//   All entries strictly younger than it are invalidated, and tail <= that entry's full pointer + 1.
//   The winning entry itself completes normally. Enqueue is blocked that cycle.
// - Commit: lanes 0..k-1 cover head..head+k-1. k = number of leading valid&ready entries, capped at COMMIT_WIDTH.
//   Their commit_* outputs register on the next edge, and head advances by k. Otherwise commit_valid=0.
// - Commit and flush may occur in the same cycle; the flush never touches entries at or older than the flush entry.
//   A CDB write on the cycle an entry is written makes it committable no earlier than the next cycle.
// - Read ports are combinational: ready and value of the indexed entry, regardless of its valid bit.
// - Wrap-around is handled by modular index arithmetic; full blocks enqueue only, never commit or CDB.
// - Reset: head=tail=0, all valid/ready=0, commit_valid=0, count=0, commit_* data=0.
//   enq_ready=1 after reset. A reset mid-operation drops all in-flight state and same-cycle inputs.
// CONFIGURATION
// ROB_CDB_BYPASS_EN defined: rs_ready/rs_value forward a same-cycle cdb write.
//   Highest port index wins, and the forward is zero-latency.
// ROB_CDB_BYPASS_EN undefined: read ports see CDB results one cycle after the write.
// TESTING
// 1 reset, enqueue 2 lanes x 8 cycles -> enq_idx 0..15, count=16, enq_ready=0 from the cycle count>=15.
// 2 fill 4, complete idx 1,0 via 2 CDB ports -> next cycle commit_valid=2'b11, idx 0,1, count=2.
// 3 entries 0..5 valid; cdb mispredict idx 2 -> entries 3..5 invalid, count=3.
//   Next enqueue gets idx 3; a later CDB to old idx 4 is ignored.
// 4 head=14 wrap: enqueue 4 -> idx 14,15,0,1; complete all -> two commit cycles, head wraps to 2, count=0.
// 5 mispredicts on idx 5 and idx 3 same cycle, head=2 -> squash from 4, tail=4, enq_ready=0 that cycle.
// 6 rs_idx=3 with cdb_idx=3 data 0xDEAD same cycle -> rs_value=0xDEAD, ready=1 with ROB_CDB_BYPASS_EN.
//   Without the macro ready=0 that cycle and 1 the next.

Source files
------------

// File: rtl/rob_superscalar_buffer_if.sv
// rtl/rob_superscalar_buffer_if.sv - dispatch, CDB, operand-read and commit bundle for the reorder buffer
interface rob_superscalar_buffer_if #(
  parameter int NUM_ENTRIES    = 16,
  parameter int DISPATCH_WIDTH = 2,
  parameter int COMMIT_WIDTH   = 2,
  parameter int CDB_PORTS      = 2,
  parameter int DATA_W         = 32,
  parameter int PAYLOAD_W      = 64
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);

  logic [DISPATCH_WIDTH-1:0]             enq_valid;
  logic [DISPATCH_WIDTH*PAYLOAD_W-1:0]   enq_payload;
  logic                                  enq_ready;
  logic [DISPATCH_WIDTH*IDX_W-1:0]       enq_idx;
  logic [CDB_PORTS-1:0]                  cdb_valid;
  logic [CDB_PORTS*IDX_W-1:0]            cdb_idx;
  logic [CDB_PORTS*DATA_W-1:0]           cdb_data;
  logic [CDB_PORTS-1:0]                  cdb_mispredict;
  logic [2*DISPATCH_WIDTH*IDX_W-1:0]     rs_idx;
  logic [2*DISPATCH_WIDTH-1:0]           rs_ready;
  logic [2*DISPATCH_WIDTH*DATA_W-1:0]    rs_value;
  logic [COMMIT_WIDTH-1:0]               commit_valid;
  logic [COMMIT_WIDTH*IDX_W-1:0]         commit_idx;
  logic [COMMIT_WIDTH*PAYLOAD_W-1:0]     commit_payload;
  logic [COMMIT_WIDTH*DATA_W-1:0]        commit_data;
  logic [IDX_W:0]                        count;

  modport master (
    output enq_valid, enq_payload, cdb_valid, cdb_idx, cdb_data, cdb_mispredict, rs_idx,
    input  enq_ready, enq_idx, rs_ready, rs_value, commit_valid, commit_idx,
           commit_payload, commit_data, count
  );

  modport slave (
    input  enq_valid, enq_payload, cdb_valid, cdb_idx, cdb_data, cdb_mispredict, rs_idx,
    output enq_ready, enq_idx, rs_ready, rs_value, commit_valid, commit_idx,
           commit_payload, commit_data, count
  );
endinterface

// File: rtl/rob_superscalar_buffer.sv
// rtl/rob_superscalar_buffer.sv - multi-issue reorder buffer with CDB completion, squash and in-order commit
// Optional: ROB_CDB_BYPASS_EN forwards same-cycle CDB writes onto the operand read ports.
module rob_superscalar_buffer #(
  parameter int NUM_ENTRIES    = 16,
  parameter int DISPATCH_WIDTH = 2,
  parameter int COMMIT_WIDTH   = 2,
  parameter int CDB_PORTS      = 2,
  parameter int DATA_W         = 32,
  parameter int PAYLOAD_W      = 64
) (
  input logic                      clk,
  input logic                      rst,
  rob_superscalar_buffer_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int PTR_W = IDX_W + 1;
  localparam int RS_N  = 2 * DISPATCH_WIDTH;

  logic [PTR_W-1:0]                  r_head;
  logic [PTR_W-1:0]                  r_tail;
  logic [NUM_ENTRIES-1:0]            r_valid;
  logic [NUM_ENTRIES-1:0]            r_ready;
  logic [DATA_W-1:0]                 r_data    [NUM_ENTRIES];
  logic [PAYLOAD_W-1:0]              r_payload [NUM_ENTRIES];
  logic [COMMIT_WIDTH-1:0]           r_commit_valid;
  logic [COMMIT_WIDTH*IDX_W-1:0]     r_commit_idx;
  logic [COMMIT_WIDTH*PAYLOAD_W-1:0] r_commit_payload;
  logic [COMMIT_WIDTH*DATA_W-1:0]    r_commit_data;

  logic [PTR_W-1:0]                  w_count;
  logic                              w_any_misp;
  logic                              w_enq_ready;
  logic [DISPATCH_WIDTH-1:0]         w_enq_fire;
  logic [PTR_W-1:0]                  w_enq_n;
  logic [IDX_W-1:0]                  w_enq_slot [DISPATCH_WIDTH];
  logic [DISPATCH_WIDTH*IDX_W-1:0]   w_enq_idx;
  logic [IDX_W-1:0]                  w_cdb_idx [CDB_PORTS];
  logic [IDX_W-1:0]                  w_cdb_age [CDB_PORTS];
  logic                              w_flush;
  logic [IDX_W-1:0]                  w_flush_age;
  logic [PTR_W-1:0]                  w_flush_tail;
  logic [NUM_ENTRIES-1:0]            w_squash;
  logic [IDX_W-1:0]                  w_commit_slot [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0]           w_commit;
  logic [PTR_W-1:0]                  w_commit_n;
  logic                              w_run;
  logic [IDX_W-1:0]                  w_rs_sel;
  logic [RS_N-1:0]                   w_rs_ready;
  logic [RS_N*DATA_W-1:0]            w_rs_value;
  logic                              w_enq_prefix_ok;
  logic                              w_cdb_dup;

  assign w_count     = r_tail - r_head;
  assign w_any_misp  = |(bus.cdb_valid & bus.cdb_mispredict);
  assign w_enq_ready = ((PTR_W'(NUM_ENTRIES) - w_count) >= PTR_W'(DISPATCH_WIDTH)) && !w_any_misp;

  always_comb begin
    w_enq_n   = '0;
    w_enq_idx = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      w_enq_fire[i] = bus.enq_valid[i] & w_enq_ready;
      w_enq_n       = w_enq_n + PTR_W'(w_enq_fire[i]);
      w_enq_slot[i] = r_tail[IDX_W-1:0] + IDX_W'(i);
      w_enq_idx[i*IDX_W +: IDX_W] = w_enq_slot[i];
    end
  end

  // Oldest valid mispredicting entry wins; age is its distance from head.
  always_comb begin
    w_flush     = 1'b0;
    w_flush_age = '0;
    for (int p = 0; p < CDB_PORTS; p++) begin
      w_cdb_idx[p] = bus.cdb_idx[p*IDX_W +: IDX_W];
      w_cdb_age[p] = w_cdb_idx[p] - r_head[IDX_W-1:0];
      if (bus.cdb_valid[p] && bus.cdb_mispredict[p] && r_valid[w_cdb_idx[p]] &&
          (!w_flush || (w_cdb_age[p] < w_flush_age))) begin
        w_flush     = 1'b1;
        w_flush_age = w_cdb_age[p];
      end
    end
    w_flush_tail = r_head + {1'b0, w_flush_age} + PTR_W'(1);
  end

  always_comb begin
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      w_squash[e] = w_flush && r_valid[e] &&
                    ((IDX_W'(e) - r_head[IDX_W-1:0]) > w_flush_age);
    end
  end

  // Commit a leading run of completed entries, never past a same-cycle flush point.
  always_comb begin
    w_run      = 1'b1;
    w_commit_n = '0;
    for (int c = 0; c < COMMIT_WIDTH; c++) begin
      w_commit_slot[c] = r_head[IDX_W-1:0] + IDX_W'(c);
      w_run = w_run && r_valid[w_commit_slot[c]] && r_ready[w_commit_slot[c]] &&
              (!w_flush || (IDX_W'(c) <= w_flush_age));
      w_commit[c] = w_run;
      w_commit_n  = w_commit_n + PTR_W'(w_run);
    end
  end

  always_comb begin
    w_rs_sel   = '0;
    w_rs_ready = '0;
    w_rs_value = '0;
    for (int r = 0; r < RS_N; r++) begin
      w_rs_sel = bus.rs_idx[r*IDX_W +: IDX_W];
      w_rs_ready[r] = r_ready[w_rs_sel];
      w_rs_value[r*DATA_W +: DATA_W] = r_data[w_rs_sel];
`ifdef ROB_CDB_BYPASS_EN
      for (int p = 0; p < CDB_PORTS; p++) begin
        if (bus.cdb_valid[p] && (bus.cdb_idx[p*IDX_W +: IDX_W] == w_rs_sel)) begin
          w_rs_ready[r] = 1'b1;
          w_rs_value[r*DATA_W +: DATA_W] = bus.cdb_data[p*DATA_W +: DATA_W];
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head           <= '0;
      r_tail           <= '0;
      r_valid          <= '0;
      r_ready          <= '0;
      r_commit_valid   <= '0;
      r_commit_idx     <= '0;
      r_commit_payload <= '0;
      r_commit_data    <= '0;
    end else begin
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
        if (w_enq_fire[i]) begin
          r_valid[w_enq_slot[i]] <= 1'b1;
          r_ready[w_enq_slot[i]] <= 1'b0;
        end
      end
      for (int p = 0; p < CDB_PORTS; p++) begin
        if (bus.cdb_valid[p] && r_valid[w_cdb_idx[p]]) begin
          r_ready[w_cdb_idx[p]] <= 1'b1;
        end
      end
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        if (w_squash[e]) begin
          r_valid[e] <= 1'b0;
          r_ready[e] <= 1'b0;
        end
      end
      r_commit_valid <= w_commit;
      for (int c = 0; c < COMMIT_WIDTH; c++) begin
        if (w_commit[c]) begin
          r_valid[w_commit_slot[c]] <= 1'b0;
          r_ready[w_commit_slot[c]] <= 1'b0;
          r_commit_idx[c*IDX_W +: IDX_W]             <= w_commit_slot[c];
          r_commit_payload[c*PAYLOAD_W +: PAYLOAD_W] <= r_payload[w_commit_slot[c]];
          r_commit_data[c*DATA_W +: DATA_W]          <= r_data[w_commit_slot[c]];
        end
      end
      r_head <= r_head + w_commit_n;
      r_tail <= w_flush ? w_flush_tail : (r_tail + w_enq_n);
    end
  end

  // Storage arrays need no reset: the valid/ready bits gate every use.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
        if (w_enq_fire[i]) begin
          r_payload[w_enq_slot[i]] <= bus.enq_payload[i*PAYLOAD_W +: PAYLOAD_W];
        end
      end
      for (int p = 0; p < CDB_PORTS; p++) begin
        if (bus.cdb_valid[p] && r_valid[w_cdb_idx[p]]) begin
          r_data[w_cdb_idx[p]] <= bus.cdb_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    w_enq_prefix_ok = ((bus.enq_valid & (bus.enq_valid + DISPATCH_WIDTH'(1))) == '0);
    w_cdb_dup = 1'b0;
    for (int p = 0; p < CDB_PORTS; p++) begin
      for (int q = p + 1; q < CDB_PORTS; q++) begin
        if (bus.cdb_valid[p] && bus.cdb_valid[q] &&
            (bus.cdb_idx[p*IDX_W +: IDX_W] == bus.cdb_idx[q*IDX_W +: IDX_W])) begin
          w_cdb_dup = 1'b1;
        end
      end
    end
  end

  a_enq_prefix: assert property (@(posedge clk) disable iff (rst) w_enq_prefix_ok);
  a_cdb_unique: assert property (@(posedge clk) disable iff (rst) !w_cdb_dup);

  assign bus.enq_ready      = w_enq_ready;
  assign bus.enq_idx        = w_enq_idx;
  assign bus.rs_ready       = w_rs_ready;
  assign bus.rs_value       = w_rs_value;
  assign bus.commit_valid   = r_commit_valid;
  assign bus.commit_idx     = r_commit_idx;
  assign bus.commit_payload = r_commit_payload;
  assign bus.commit_data    = r_commit_data;
  assign bus.count          = w_count;
endmodule
